dpram_param: RTL and testbench
==============================

// Module: dpram_param
// PURPOSE
//   Parametrised true dual-port RAM, successor to the fixed 1Kx16 dual-port RAM.
//   Each port has independent write and read addresses, per-byte write enables
//   and a registered read pipeline with a valid strobe.
//   Adds write-collision arbitration, a selectable read-during-write mode, and a
//   post-reset memory-clear sequencer. Sits as a shared buffer between two masters.
// PARAMETERS
//   DATA_W    16    data width per port; must be a multiple of 8
//   ADDR_W    10    address width
//   DEPTH     1024  number of words; DEPTH <= 2**ADDR_W
//   RD_LAT    1     read latency in cycles; legal values 1 or 2
//   WR_PRIO   0     same-address write collision winner: 0 = port 1, 1 = port 2
//   RDW_MODE  0     read of a word written in the same cycle: 0 = old data, 1 = new data
//   CNT_W     16    width of the collision counter
// PORTS
//   clk             in   1         single clock; all logic on the rising edge
//   rst             in   1         synchronous reset, active high
//   we_p1           in   1         port 1 write enable
//   add_write_p1    in   ADDR_W    port 1 write address
//   input_data_p1   in   DATA_W    port 1 write data
//   be_p1           in   DATA_W/8  port 1 byte enables (bit i -> byte i)
//   re_p1           in   1         port 1 read enable
//   add_read_p1     in   ADDR_W    port 1 read address
//   output_data_p1  out  DATA_W    port 1 read data
//   valid_p1        out  1         port 1 read data valid, one-cycle pulse per read
//   we_p2, add_write_p2, input_data_p2, be_p2, re_p2, add_read_p2,
//   output_data_p2, valid_p2       port 2 equivalents, same widths
//   init_busy       out  1         high during reset and memory clear
//   coll_pulse      out  1         one-cycle pulse after a same-address write collision
//   coll_cnt        out  CNT_W     saturating count of write collisions
// BEHAVIOUR
//   - Reset: while rst=1, output_data_*=0, valid_*=0, coll_pulse=0, coll_cnt=0,
//     init_busy=1, FSM=CLEAR, clear pointer=0. Pending read pipeline is flushed.
//   - FSM CLEAR: each edge with rst=0 writes 0 to mem[ptr] and increments ptr.
//     The edge that writes DEPTH-1 moves the FSM to READY and drops init_busy.
//     rst=1 in any state restarts CLEAR from ptr=0.
//   - In CLEAR, all we_*/re_* are ignored: no write, no valid, no collision.
//   - FSM READY: stays in READY until rst.
//   - Write: at an edge with we_pX=1, bytes of mem[add_write_pX] with be_pX=1
//     take input_data_pX. Other bytes are unchanged. be_pX=0 writes nothing.
//   - Collision: we_p1=we_p2=1 and equal addresses -> only the WR_PRIO winner
//     writes (its be); the loser is discarded entirely. On the next cycle
//     coll_pulse=1 and coll_cnt increments, saturating at 2**CNT_W-1.
//     Different addresses on the same edge -> both writes apply, no collision.
//   - Read: re_pX=1 sampled at edge N (READY) -> output_data_pX valid at edge
//     N+RD_LAT-1 output register update, i.e. visible RD_LAT cycles after the request.
//     valid_pX=1 for exactly that cycle. Back-to-back reads give one result per cycle.
//     output_data_pX holds its last value when valid_pX=0.
//   - Read-during-write: read address equals either port's effective write address
//     on the same edge. RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns
//     the merged post-arbitration word.
//   - Address >= DEPTH: write ignored (no collision counted); read returns 0 with valid.
//   - Both ports may read the same address on the same edge; both return identical data.
// STRUCTURE
//   - Package dpram_pkg: typedef enum {ST_CLEAR, ST_READY} dpram_state_t;
//     constants RDW_OLD=0, RDW_NEW=1, PRIO_P1=0, PRIO_P2=1.
//   - Sub-module dpram_rd_pipe (RD_LAT-deep data+valid shift register with sync
//     flush). One instance per port.
//   - Top module: memory array, byte-merge/arbitration, clear FSM, collision counter.
// TESTING
//   1. rst for 3 cycles, release; init_busy=1 for exactly 1024 cycles. Then read
//      addr 0x3FF -> 0x0000, valid_p1 pulses once.
//   2. P1 write 0x001=0xAAAA be=11; P2 read 0x001 next cycle -> 0xAAAA with
//      RD_LAT=1, and again with RD_LAT=2 (one cycle later).
//   3. Byte enables: write 0x002=0x1234 be=11, then 0xABCD be=10; read -> 0xAB34.
//   4. Collision: P1 writes 0x005=0x9ABC and P2 writes 0x005=0xDEF0, same edge.
//      WR_PRIO=0 reads 0x9ABC; WR_PRIO=1 reads 0xDEF0. coll_pulse=1 once,
//      coll_cnt=1. Distinct addresses -> coll_cnt unchanged.
//   5. RDW: 0x006=0x1111, then write 0x2222 and read 0x006 on the same edge.
//      RDW_MODE=0 -> 0x1111; RDW_MODE=1 -> 0x2222.
//   6. Reset mid-op: assert rst with reads in flight; valid stays 0. Re-clear
//      runs 1024 cycles, with we_p1 and re_p1 held high and ignored. Then 0x001 reads 0x0000.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
// Clear-sequencer states plus read-during-write and priority selectors.
package dpram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } dpram_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int PRIO_P1 = 0;
  localparam int PRIO_P2 = 1;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-data pipeline: LAT-deep data+valid shift register.
// Data stages only load on valid so the output holds between reads.
module dpram_rd_pipe
  import dpram_pkg::*;
#(
  parameter int W   = 16,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         flush_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic [LAT-1:0] v_q;
  logic [W-1:0]   d_q [LAT];

  always_ff @(posedge clk) begin
    if (flush_i) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= vld_i;
      if (vld_i) d_q[0] <= data_i;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign vld_o  = v_q[LAT-1];
  assign data_o = d_q[LAT-1];

endmodule

// File: rtl/dpram_param.sv
// Parametrised true dual-port RAM with byte enables, write arbitration,
// read-during-write selection and a post-reset memory clear.
module dpram_param
  import dpram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int RD_LAT   = 1,
  parameter int WR_PRIO  = 0,
  parameter int RDW_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_p1,
  input  logic [ADDR_W-1:0]     add_write_p1,
  input  logic [DATA_W-1:0]     input_data_p1,
  input  logic [DATA_W/8-1:0]   be_p1,
  input  logic                  re_p1,
  input  logic [ADDR_W-1:0]     add_read_p1,
  output logic [DATA_W-1:0]     output_data_p1,
  output logic                  valid_p1,
  input  logic                  we_p2,
  input  logic [ADDR_W-1:0]     add_write_p2,
  input  logic [DATA_W-1:0]     input_data_p2,
  input  logic [DATA_W/8-1:0]   be_p2,
  input  logic                  re_p2,
  input  logic [ADDR_W-1:0]     add_read_p2,
  output logic [DATA_W-1:0]     output_data_p2,
  output logic                  valid_p2,
  output logic                  init_busy,
  output logic                  coll_pulse,
  output logic [CNT_W-1:0]      coll_cnt
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  dpram_state_t      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              coll_q;
  logic [CNT_W-1:0]  cnt_q;

  logic rdy, ok1, ok2, okr1, okr2;
  logic coll, w1, w2;
  logic [DATA_W-1:0] rd1, rd2;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] o,
    input logic [DATA_W-1:0] n,
    input logic [NB-1:0]     be
  );
    merge = o;
    for (int b = 0; b < NB; b++)
      if (be[b]) merge[b*8 +: 8] = n[b*8 +: 8];
  endfunction

  assign rdy  = (state_q == ST_READY) && !rst;
  assign ok1  = we_p1 && ({1'b0, add_write_p1} < DEPTH_L);
  assign ok2  = we_p2 && ({1'b0, add_write_p2} < DEPTH_L);
  assign okr1 = {1'b0, add_read_p1} < DEPTH_L;
  assign okr2 = {1'b0, add_read_p2} < DEPTH_L;

  // The losing port of a same-address collision is dropped entirely.
  assign coll = rdy && ok1 && ok2 && (add_write_p1 == add_write_p2);
  assign w1   = rdy && ok1 && !(coll && WR_PRIO == PRIO_P2);
  assign w2   = rdy && ok2 && !(coll && WR_PRIO == PRIO_P1);

  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_CLEAR) begin
      mem[ptr_q[IW-1:0]] <= '0;
    end else begin
      if (w1)
        mem[add_write_p1[IW-1:0]] <=
          merge(mem[add_write_p1[IW-1:0]], input_data_p1, be_p1);
      if (w2)
        mem[add_write_p2[IW-1:0]] <=
          merge(mem[add_write_p2[IW-1:0]], input_data_p2, be_p2);
    end
  end

  always_comb begin
    rd1 = '0;
    if (okr1) begin
      rd1 = mem[add_read_p1[IW-1:0]];
      if (RDW_MODE == RDW_NEW) begin
        if (w1 && add_write_p1 == add_read_p1)
          rd1 = merge(rd1, input_data_p1, be_p1);
        if (w2 && add_write_p2 == add_read_p1)
          rd1 = merge(rd1, input_data_p2, be_p2);
      end
    end
  end

  always_comb begin
    rd2 = '0;
    if (okr2) begin
      rd2 = mem[add_read_p2[IW-1:0]];
      if (RDW_MODE == RDW_NEW) begin
        if (w1 && add_write_p1 == add_read_p2)
          rd2 = merge(rd2, input_data_p1, be_p1);
        if (w2 && add_write_p2 == add_read_p2)
          rd2 = merge(rd2, input_data_p2, be_p2);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      coll_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      coll_q  <= coll;
      if (coll && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  dpram_rd_pipe #(.W(DATA_W), .LAT(RD_LAT)) u_pipe1 (
    .clk     (clk),
    .flush_i (rst),
    .vld_i   (re_p1 && rdy),
    .data_i  (rd1),
    .vld_o   (valid_p1),
    .data_o  (output_data_p1)
  );

  dpram_rd_pipe #(.W(DATA_W), .LAT(RD_LAT)) u_pipe2 (
    .clk     (clk),
    .flush_i (rst),
    .vld_i   (re_p2 && rdy),
    .data_i  (rd2),
    .vld_o   (valid_p2),
    .data_o  (output_data_p2)
  );

  assign init_busy  = rst || (state_q == ST_CLEAR);
  assign coll_pulse = coll_q;
  assign coll_cnt   = cnt_q;

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: two instances (old-data/P1-prio/lat1 and
// new-data/P2-prio/lat2 with a wider address) share one stimulus stream.
module tb_dpram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we1, we2, re1, re2;
  logic [10:0] wa1, wa2, ra1, ra2;
  logic [15:0] wd1, wd2;
  logic [1:0]  be1, be2;

  logic [15:0] oa1, oa2, ob1, ob2;
  logic        va1, va2, vb1, vb2;
  logic        busy_a, busy_b, cp_a, cp_b;
  logic [15:0] cnt_a, cnt_b;

  dpram_param u_a (
    .clk(clk), .rst(rst),
    .we_p1(we1), .add_write_p1(wa1[9:0]), .input_data_p1(wd1), .be_p1(be1),
    .re_p1(re1), .add_read_p1(ra1[9:0]),
    .output_data_p1(oa1), .valid_p1(va1),
    .we_p2(we2), .add_write_p2(wa2[9:0]), .input_data_p2(wd2), .be_p2(be2),
    .re_p2(re2), .add_read_p2(ra2[9:0]),
    .output_data_p2(oa2), .valid_p2(va2),
    .init_busy(busy_a), .coll_pulse(cp_a), .coll_cnt(cnt_a)
  );

  dpram_param #(
    .ADDR_W(11), .DEPTH(1024), .RD_LAT(2), .WR_PRIO(1), .RDW_MODE(1)
  ) u_b (
    .clk(clk), .rst(rst),
    .we_p1(we1), .add_write_p1(wa1), .input_data_p1(wd1), .be_p1(be1),
    .re_p1(re1), .add_read_p1(ra1),
    .output_data_p1(ob1), .valid_p1(vb1),
    .we_p2(we2), .add_write_p2(wa2), .input_data_p2(wd2), .be_p2(be2),
    .re_p2(re2), .add_read_p2(ra2),
    .output_data_p2(ob2), .valid_p2(vb2),
    .init_busy(busy_b), .coll_pulse(cp_b), .coll_cnt(cnt_b)
  );

  typedef struct {
    logic        we1; logic [10:0] wa1; logic [15:0] wd1; logic [1:0] be1;
    logic        we2; logic [10:0] wa2; logic [15:0] wd2; logic [1:0] be2;
    logic        re1; logic [10:0] ra1;
    logic        re2; logic [10:0] ra2;
    logic [15:0] e1a, e1b, e2a, e2b;
    logic        cpa, cpb;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t q[4][$];
  vec_t tv[17];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  logic [3:0]  vv;
  logic [15:0] od[4];
  assign vv = {vb2, vb1, va2, va1};
  assign od[0] = oa1;
  assign od[1] = oa2;
  assign od[2] = ob1;
  assign od[3] = ob2;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Streams: 0 = A port1, 1 = A port2, 2 = B port1, 3 = B port2.
  task automatic push(input int k, input logic [15:0] d);
    exp_t e;
    e.d   = d;
    e.due = cyc + ((k >= 2) ? 2 : 1);
    q[k].push_back(e);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (vv[k]) begin
        if (q[k].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL stray_valid%0d: got valid data %h expected no valid",
                   k, od[k]);
        end else begin
          exp_t e;
          e = q[k].pop_front();
          chk($sformatf("rd%0d_data", k), od[k], e.d);
          chk($sformatf("rd%0d_cycle", k), cyc, e.due);
        end
      end
    end
  end

  task automatic idle();
    we1 = 0; wa1 = '0; wd1 = '0; be1 = '0; re1 = 0; ra1 = '0;
    we2 = 0; wa2 = '0; wd2 = '0; be2 = '0; re2 = 0; ra2 = '0;
  endtask

  task automatic apply(input vec_t v, input string nm);
    we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1; be1 = v.be1;
    we2 = v.we2; wa2 = v.wa2; wd2 = v.wd2; be2 = v.be2;
    re1 = v.re1; ra1 = v.ra1; re2 = v.re2; ra2 = v.ra2;
    if (v.re1) begin push(0, v.e1a); push(2, v.e1b); end
    if (v.re2) begin push(1, v.e2a); push(3, v.e2b); end
    @(posedge clk); #1;
    chk({nm, "_cp_a"}, cp_a, v.cpa);
    chk({nm, "_cp_b"}, cp_b, v.cpb);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_busy_a"}, busy_a, 1);
    chk({nm, "_busy_b"}, busy_b, 1);
    chk({nm, "_valid"}, vv, 0);
    chk({nm, "_out_a"}, {oa1, oa2}, 0);
    chk({nm, "_out_b"}, {ob1, ob2}, 0);
    chk({nm, "_cnt"}, {cnt_a, cnt_b}, 0);
    chk({nm, "_cp"}, {cp_a, cp_b}, 0);
  endtask

  // Counts busy cycles after reset release; inputs are dropped the moment
  // both instances report ready so nothing held during clear leaks through.
  task automatic clear_run(input string nm);
    int na = 0;
    int nb = 0;
    int n = 0;
    while ((busy_a || busy_b) && n < 1200) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      @(posedge clk); #1;
      n++;
    end
    idle();
    chk({nm, "_busy_cycles_a"}, na, 1024);
    chk({nm, "_busy_cycles_b"}, nb, 1024);
  endtask

  initial begin
    vec_t v;
    tv[0]  = '{1,11'h001,16'hAAAA,2'b11, 0,0,0,0, 0,0, 0,0,
               0,0,0,0, 0,0};
    tv[1]  = '{0,0,0,0, 0,0,0,0, 0,0, 1,11'h001,
               0,0,16'hAAAA,16'hAAAA, 0,0};
    tv[2]  = '{1,11'h002,16'h1234,2'b11, 0,0,0,0, 0,0, 0,0,
               0,0,0,0, 0,0};
    tv[3]  = '{1,11'h002,16'hABCD,2'b10, 0,0,0,0, 0,0, 0,0,
               0,0,0,0, 0,0};
    tv[4]  = '{0,0,0,0, 0,0,0,0, 1,11'h002, 0,0,
               16'hAB34,16'hAB34,0,0, 0,0};
    tv[5]  = '{1,11'h005,16'h9ABC,2'b11, 1,11'h005,16'hDEF0,2'b11,
               0,0, 0,0, 0,0,0,0, 1,1};
    tv[6]  = '{0,0,0,0, 0,0,0,0, 1,11'h005, 1,11'h005,
               16'h9ABC,16'hDEF0,16'h9ABC,16'hDEF0, 0,0};
    tv[7]  = '{1,11'h007,16'h7777,2'b11, 1,11'h008,16'h8888,2'b11,
               0,0, 0,0, 0,0,0,0, 0,0};
    tv[8]  = '{0,0,0,0, 0,0,0,0, 1,11'h007, 1,11'h008,
               16'h7777,16'h7777,16'h8888,16'h8888, 0,0};
    tv[9]  = '{1,11'h006,16'h1111,2'b11, 0,0,0,0, 0,0, 0,0,
               0,0,0,0, 0,0};
    tv[10] = '{1,11'h006,16'h2222,2'b11, 0,0,0,0, 0,0, 1,11'h006,
               0,0,16'h1111,16'h2222, 0,0};
    tv[11] = '{0,0,0,0, 1,11'h009,16'h5555,2'b11, 1,11'h009, 0,0,
               16'h0000,16'h5555,0,0, 0,0};
    tv[12] = '{0,0,0,0, 0,0,0,0, 1,11'h009, 1,11'h009,
               16'h5555,16'h5555,16'h5555,16'h5555, 0,0};
    tv[13] = '{1,11'h001,16'hFFFF,2'b00, 0,0,0,0, 0,0, 0,0,
               0,0,0,0, 0,0};
    tv[14] = '{0,0,0,0, 0,0,0,0, 1,11'h001, 0,0,
               16'hAAAA,16'hAAAA,0,0, 0,0};
    tv[15] = '{1,11'h7F0,16'h1234,2'b11, 1,11'h7F0,16'h4321,2'b11,
               0,0, 0,0, 0,0,0,0, 1,0};
    tv[16] = '{0,0,0,0, 0,0,0,0, 1,11'h7F0, 0,0,
               16'h1234,16'h0000,0,0, 0,0};

    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 0;
    clear_run("clear1");

    v = '{default: 0};
    v.re1 = 1; v.ra1 = 11'h3FF;
    apply(v, "rd3ff");

    for (int i = 0; i < 17; i++) apply(tv[i], $sformatf("vec%0d", i));
    idle();
    repeat (4) @(posedge clk);
    #1;
    chk("coll_cnt_a", cnt_a, 2);
    chk("coll_cnt_b", cnt_b, 1);
    chk("hold_a_p1", oa1, 16'h1234);
    chk("hold_a_p2", oa2, 16'h5555);
    chk("hold_b_p1", ob1, 16'h0000);
    chk("hold_b_p2", ob2, 16'h5555);

    // Reset with a read outstanding in the two-stage pipe of instance B.
    re1 = 1; ra1 = 11'h001;
    push(0, 16'hAAAA);
    @(posedge clk); #1;
    rst = 1;
    we1 = 1; wa1 = 11'h001; wd1 = 16'hFFFF; be1 = 2'b11;
    @(posedge clk); #1;
    check_reset("midrst");
    @(posedge clk); #1;
    rst = 0;
    clear_run("clear2");

    v = '{default: 0};
    v.re1 = 1; v.ra1 = 11'h001;
    v.re2 = 1; v.ra2 = 11'h001;
    apply(v, "rd_after_clear");
    idle();
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("q%0d_empty", k), q[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
